// File: rtl/ps2_receiver.sv
// ----------------------------------------------------------------------------
// ps2_receiver
//
// Oversampling PS/2 device-to-host receiver. The raw PS/2 clock and data pins
// are brought into the read_clk domain through equal-depth synchronisers, a
// falling edge of the synchronised clock is detected, and the 11-bit frame
// (start, 8 data bits LSB first, odd parity, stop) is deframed by a small FSM.
// A frame in progress that stalls for TIMEOUT_CYCLES cycles is aborted.
//
// Parameters
//   SYNC_STAGES     flop depth of each pin synchroniser (>= 2)
//   TIMEOUT_CYCLES  idle read_clk cycles mid-frame before the frame is aborted
//
// Ports
//   read_clk   in   system clock, all state updates on its rising edge
//   reset      in   asynchronous, active-high reset
//   ps2_clock  in   raw PS/2 clock pin (idles high)
//   ps2_data   in   raw PS/2 data pin (idles high)
//   rx_data    out  last validated byte, held until the next valid frame
//   rx_done    out  one-cycle pulse when rx_data has just been updated
//   rx_error   out  one-cycle pulse on parity, stop-bit or timeout failure
//   busy       out  high while a frame is in progress
// ----------------------------------------------------------------------------
module ps2_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       read_clk,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_error,
    output logic       busy
);

    // Guard against a zero-width counter for degenerate timeout values.
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers. Both chains have the same depth so the data
    // sample lines up with the detected clock edge. They reset to the
    // idle (high) level so no edge is seen when reset is released.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   prev_clk_reg;
    logic                   sync_clk;
    logic                   sync_data;
    logic                   fall;

    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            prev_clk_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clock};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
            prev_clk_reg  <= sync_clk;
        end
    end

    assign sync_clk  = clk_sync_reg[SYNC_STAGES-1];
    assign sync_data = data_sync_reg[SYNC_STAGES-1];
    assign fall      = prev_clk_reg & ~sync_clk;

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs.
    // ------------------------------------------------------------------
    state_t             state_reg;
    logic [7:0]         shreg_reg;
    logic [2:0]         bit_cnt_reg;
    logic [TMO_W-1:0]   tmo_cnt_reg;
    logic               par_ok_reg;

    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shreg_reg   <= 8'h00;
            bit_cnt_reg <= 3'd0;
            tmo_cnt_reg <= '0;
            par_ok_reg  <= 1'b0;
            rx_data     <= 8'h00;
            rx_done     <= 1'b0;
            rx_error    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            rx_done  <= 1'b0;
            rx_error <= 1'b0;

            if (state_reg == IDLE) begin
                tmo_cnt_reg <= '0;
                // A fall with data high in IDLE is a spurious edge: ignore it.
                if (fall && !sync_data) begin
                    state_reg   <= DATA;
                    bit_cnt_reg <= 3'd0;
                    busy        <= 1'b1;
                end
            end else if (fall) begin
                tmo_cnt_reg <= '0;
                case (state_reg)
                    DATA: begin
                        // LSB arrives first, so shift in from the top.
                        shreg_reg   <= {sync_data, shreg_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end
                    end
                    PARITY: begin
                        // Odd parity over data and parity bit: XOR of 1 is good.
                        par_ok_reg <= ^{shreg_reg, sync_data};
                        state_reg  <= STOP;
                    end
                    STOP: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        if (sync_data && par_ok_reg) begin
                            rx_data <= shreg_reg;
                            rx_done <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end else if (tmo_cnt_reg == TMO_LAST) begin
                // Clock stalled mid-frame: abort and drop the partial byte.
                rx_error    <= 1'b1;
                state_reg   <= IDLE;
                busy        <= 1'b0;
                bit_cnt_reg <= 3'd0;
                tmo_cnt_reg <= '0;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// ----------------------------------------------------------------------------
// tb_ps2_receiver
//
// Drives PS/2 frames into ps2_receiver (directed cases plus a randomized
// stream) and compares every rx_done / rx_error event against a frame-level
// reference: a frame is accepted when its data plus parity bit hold an odd
// number of ones and its stop bit is 1, otherwise it is reported as an error.
// ----------------------------------------------------------------------------
module tb_ps2_receiver;

    localparam int TMO = 4096;

    logic       read_clk = 1'b0;
    logic       reset;
    logic       ps2_clock;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_error;
    logic       busy;

    ps2_receiver #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .read_clk (read_clk),
        .reset    (reset),
        .ps2_clock(ps2_clock),
        .ps2_data (ps2_data),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_error (rx_error),
        .busy     (busy)
    );

    always #5 read_clk = ~read_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge read_clk) cyc <= cyc + 1;

    // Reference model state
    bit         exp_kind[$];   // 1 = rx_done expected, 0 = rx_error expected
    logic [7:0] exp_data[$];
    logic [7:0] model_rx = 8'h00;

    int last_fall_cyc = 0;
    int stop_fall_cyc = 0;
    int last_done_cyc = 0;
    int last_err_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Event monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge read_clk) begin
        if (!reset && (rx_done || rx_error)) begin
            check("done_error_exclusive", {31'd0, rx_done & rx_error}, 32'd0);
            check("event_pending", {31'd0, exp_kind.size() != 0}, 32'd1);
            if (rx_done) last_done_cyc = cyc;
            if (rx_error) last_err_cyc = cyc;
            if (exp_kind.size() != 0) begin
                check("event_kind", {31'd0, rx_done}, {31'd0, exp_kind[0]});
                if (rx_done && exp_kind[0]) begin
                    check("rx_data_on_done", {24'd0, rx_data}, {24'd0, exp_data[0]});
                end
                void'(exp_kind.pop_front());
                void'(exp_data.pop_front());
            end
            $display("event t=%0t done=%0b error=%0b rx_data=0x%02h", $time, rx_done, rx_error, rx_data);
        end
    end

    function automatic int hp();
        return int'($urandom_range(2, 6));
    endfunction

    // One PS/2 bit: data changes while clock is high, then clock pulses low.
    task automatic ps2_bit(input logic b, input int hi, input int lo);
        ps2_data = b;
        repeat (hi) @(negedge read_clk);
        ps2_clock = 1'b0;
        last_fall_cyc = cyc;
        repeat (lo) @(negedge read_clk);
        ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        bit ok;
        ps2_bit(1'b0, hp(), hp());
        for (int i = 0; i < 8; i++) begin
            ps2_bit(d[i], hp(), hp());
            if (i == 0) check("busy_mid_frame", {31'd0, busy}, 32'd1);
        end
        ps2_bit(p, hp(), hp());
        ps2_data = s;
        repeat (hp()) @(negedge read_clk);
        ps2_clock = 1'b0;
        last_fall_cyc = cyc;
        stop_fall_cyc = cyc;
        // Expectation is queued now, before the strobe can appear.
        ok = ($countones({d, p}) % 2 == 1) && (s == 1'b1);
        exp_kind.push_back(ok);
        exp_data.push_back(d);
        if (ok) model_rx = d;
        repeat (hp()) @(negedge read_clk);
        ps2_clock = 1'b1;
        $display("frame data=0x%02h parity=%0b stop=%0b expect=%s", d, p, s, ok ? "done" : "error");
    endtask

    task automatic settle_and_check(input string tag);
        ps2_data = 1'b1;
        repeat (8) @(negedge read_clk);
        check({tag, "_pending"}, exp_kind.size(), 32'd0);
        check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, model_rx});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;

        reset     = 1'b1;
        ps2_clock = 1'b1;
        ps2_data  = 1'b1;
        repeat (3) @(negedge read_clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("reset_rx_error", {31'd0, rx_error}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge read_clk);

        // Valid frame 0x1C with latency check
        send_frame(8'h1C, 1'b0, 1'b1);
        settle_and_check("f1C");
        check("done_latency", last_done_cyc - stop_fall_cyc, 32'd3);

        // Bad parity, bad stop, then extremes
        send_frame(8'hF0, 1'b0, 1'b1);
        settle_and_check("fF0_badpar");
        send_frame(8'h5A, good_par(8'h5A), 1'b0);
        settle_and_check("f5A_badstop");
        send_frame(8'h00, 1'b1, 1'b1);
        settle_and_check("f00");
        send_frame(8'hFF, 1'b1, 1'b1);
        settle_and_check("fFF");

        // Timeout: start + 4 data bits then the clock stops
        ps2_bit(1'b0, hp(), hp());
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, hp(), hp());
        exp_kind.push_back(1'b0);
        exp_data.push_back(8'h00);
        repeat (TMO + 10) @(negedge read_clk);
        check("tmo_latency", last_err_cyc - last_fall_cyc, TMO + 3);
        settle_and_check("timeout");
        send_frame(8'h29, good_par(8'h29), 1'b1);
        settle_and_check("f29");

        // Asynchronous reset mid-frame (after data bit 3)
        ps2_bit(1'b0, hp(), hp());
        for (int i = 0; i < 4; i++) ps2_bit(i[0], hp(), hp());
        repeat (2) @(negedge read_clk);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_rx_done", {31'd0, rx_done}, 32'd0);
        check("async_rst_rx_error", {31'd0, rx_error}, 32'd0);
        model_rx  = 8'h00;
        ps2_data  = 1'b1;
        ps2_clock = 1'b1;
        @(negedge read_clk);
        reset = 1'b0;
        repeat (4) @(negedge read_clk);
        send_frame(8'h76, good_par(8'h76), 1'b1);
        settle_and_check("f76_after_reset");

        // Back-to-back frames
        send_frame(8'h12, good_par(8'h12), 1'b1);
        send_frame(8'h34, good_par(8'h34), 1'b1);
        settle_and_check("b2b");

        // Randomized stream with occasional corruption and spurious edges
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            p = good_par(d);
            if ($urandom_range(0, 4) == 0) p = ~p;
            s = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 7) == 0) begin
                ps2_bit(1'b1, hp(), hp());
                $display("spurious idle edge");
            end
            send_frame(d, p, s);
            if ($urandom_range(0, 2) == 0) settle_and_check("rand");
        end
        settle_and_check("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
